lcd_bus_arbiter: RTL and testbench

Shares the single 4-bit HD44780 LCD bus between two independent requesters, for example the init/text sequencer and the button-driven menu writer. Each requester submits one byte at a time, with its register select, over a valid/ready handshake. The block arbitrates round-robin, splits the byte into upper and lower nibbles, and generates the setup, enable-pulse and post-command delays. After the bus-level power-on init has completed, it is the only block that drives the LCD pins.

---
 rtl/lcd_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter driving a 4-bit HD44780 bus: two byte requesters, nibble split, setup/enable/gap timing.
// Latency: accept edge k, IDLE again at k+2*T_SETUP+2*T_PULSE+gap; ready is held low whenever not IDLE.
module lcd_bus_arbiter #(
  parameter int T_SETUP = 40000,
  parameter int T_PULSE = 100000,
  parameter int T_CMD   = 40000,
  parameter int T_CLR   = 200000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, SETUP_LO, PULSE_LO, GAP
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        last_grant_q;
  logic        grant_id_q;
  logic [3:0]  lcd_data_q;
  logic        lcd_rs_q;
  logic        lcd_en_q;

  logic        grant;
  logic        accept;
  logic        sel_rs;
  logic [7:0]  sel_byte;
  logic        is_clr;
  logic [31:0] lim;

  // A lone requester wins; on a tie (or no request) the one not served last is offered.
  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = (state_q == IDLE) && !grant;
  assign req1_ready = (state_q == IDLE) && grant;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign sel_rs     = grant ? req1_rs : req0_rs;
  assign sel_byte   = grant ? req1_byte : req0_byte;

  // Clear display / return home need the long settle time.
  assign is_clr = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  always_comb begin
    lim = 32'd0;
    case (state_q)
      SETUP_HI, SETUP_LO: lim = 32'(T_SETUP - 1);
      PULSE_HI, PULSE_LO: lim = 32'(T_PULSE - 1);
      GAP:                lim = is_clr ? 32'(T_CLR - 1) : 32'(T_CMD - 1);
      default:            lim = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      byte_q       <= 8'h00;
      rs_q         <= 1'b0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      lcd_data_q   <= 4'h0;
      lcd_rs_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        byte_q       <= sel_byte;
        rs_q         <= sel_rs;
        last_grant_q <= grant;
        grant_id_q   <= grant;
        lcd_data_q   <= sel_byte[7:4];
        lcd_rs_q     <= sel_rs;
        lcd_en_q     <= 1'b0;
        cnt_q        <= 32'd0;
        state_q      <= SETUP_HI;
      end
    end else if (cnt_q == lim) begin
      cnt_q <= 32'd0;
      case (state_q)
        SETUP_HI: begin
          state_q  <= PULSE_HI;
          lcd_en_q <= 1'b1;
        end
        PULSE_HI: begin
          state_q    <= SETUP_LO;
          lcd_en_q   <= 1'b0;
          lcd_data_q <= byte_q[3:0];
        end
        SETUP_LO: begin
          state_q  <= PULSE_LO;
          lcd_en_q <= 1'b1;
        end
        PULSE_LO: begin
          state_q  <= GAP;
          lcd_en_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          lcd_en_q <= 1'b0;
        end
      endcase
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with short timing parameters.
module tb_lcd_bus_arbiter;

  localparam int TS = 4;
  localparam int TP = 6;
  localparam int TC = 3;
  localparam int TL = 20;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_byte = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_byte = 8'h00;
  logic       req0_ready, req1_ready;
  logic [3:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy, grant_id;

  lcd_bus_arbiter #(.T_SETUP(TS), .T_PULSE(TP), .T_CMD(TC), .T_CLR(TL)) dut (
    .clk(clk), .nrst(nrst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_byte(req0_byte), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_byte(req1_byte), .req1_ready(req1_ready),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic       rs;
    logic [7:0] b;
    int         k;
    int         n;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Reference model of arbitration and timing, plus output monitor.
  int   m_idle_at;
  logic m_last;
  logic m_grant;
  logic m_idle;
  logic prev_en, prev_busy;
  int   nrise;
  int   rise_cyc[2];
  logic [3:0] rise_dat[2];
  logic [3:0] hold_nib;

  always @(negedge clk) begin
    if (!nrst) begin
      sb.delete();
      m_idle_at = 0;
      m_last    = 1'b1;
      prev_en   = 1'b0;
      prev_busy = 1'b0;
      nrise     = 0;
    end else begin
      m_idle  = (cyc >= m_idle_at);
      m_grant = ~m_last;
      if (req0_valid && !req1_valid) m_grant = 1'b0;
      else if (req1_valid && !req0_valid) m_grant = 1'b1;
      chk("ready0", req0_ready, m_idle && !m_grant);
      chk("ready1", req1_ready, m_idle && m_grant);
      chk("busy", busy, !m_idle);
      if (m_idle && (m_grant ? req1_valid : req0_valid)) begin
        exp_t e;
        e.id = m_grant;
        e.rs = m_grant ? req1_rs : req0_rs;
        e.b  = m_grant ? req1_byte : req0_byte;
        e.k  = cyc + 1;
        e.n  = 2 * TS + 2 * TP + ((!e.rs && e.b >= 8'h01 && e.b <= 8'h03) ? TL : TC);
        sb.push_back(e);
        m_last    = m_grant;
        m_idle_at = e.k + e.n;
      end
      if (lcd_en && !prev_en) begin
        if (sb.size() == 0) chk("en_unexpected", 1, 0);
        else begin
          chk("rs_at_en", lcd_rs, sb[0].rs);
          if (nrise < 2) begin
            rise_cyc[nrise] = cyc;
            rise_dat[nrise] = lcd_data;
          end
          nrise++;
        end
        hold_nib = lcd_data;
      end else if (lcd_en) begin
        chk("data_stable", lcd_data, hold_nib);
      end
      if (prev_busy && !busy) begin
        if (sb.size() == 0) chk("busy_fall_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("grant_id", grant_id, e.id);
          chk("n_pulses", nrise, 2);
          chk("hi_nibble", rise_dat[0], e.b[7:4]);
          chk("lo_nibble", rise_dat[1], e.b[3:0]);
          chk("en1_rise", rise_cyc[0], e.k + TS);
          chk("en2_rise", rise_cyc[1], e.k + 2 * TS + TP);
          chk("idle_edge", cyc, e.k + e.n);
          chk("rs_hold", lcd_rs, e.rs);
        end
        nrise = 0;
      end
      prev_en   = lcd_en;
      prev_busy = busy;
    end
  end

  task automatic send(input int who, input logic rs, input logic [7:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    if (who == 0) begin req0_valid = 1; req0_rs = rs; req0_byte = b; end
    else begin req1_valid = 1; req1_rs = rs; req1_byte = b; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (who == 0) ? req0_ready : req1_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (who == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && !req0_valid && !req1_valid;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    nrst = 1;

    // Single data byte from requester 0
    send(0, 1'b1, 8'h4D);
    wait_idle();

    // Both requesters contending continuously
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_byte = 8'h41;
    req1_valid = 1; req1_rs = 1; req1_byte = 8'h43;
    repeat (100) @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Clear command versus same byte as data
    send(1, 1'b0, 8'h01);
    wait_idle();
    send(1, 1'b1, 8'h01);
    wait_idle();
    send(0, 1'b0, 8'h02);
    wait_idle();

    // Requester 1 waiting while requester 0 is in flight
    send(0, 1'b1, 8'h30);
    send(1, 1'b1, 8'h5A);
    wait_idle();

    // Asynchronous reset during the first enable pulse
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_byte = 8'h41;
    req1_valid = 1; req1_rs = 1; req1_byte = 8'h43;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = lcd_en;
    end
    if (!ok) chk("en_timeout", 0, 1);
    @(posedge clk); #3;
    nrst = 0;
    #1;
    chk("arst_en", lcd_en, 0);
    chk("arst_data", lcd_data, 0);
    chk("arst_rs", lcd_rs, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant_id", grant_id, 0);
    @(posedge clk); @(posedge clk); #1;
    nrst = 1;
    repeat (30) @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Valid pulse that never meets an accept edge
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_byte = 8'hAA;
    #2;
    req0_valid = 0;
    repeat (30) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
